// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: decodes one instruction per push into a control bundle
// and buffers it in a small FIFO in front of the execute/issue stage.
module rv_decode_stage #(
    parameter int XLEN  = 64,
    parameter bit HAS_M = 1'b1,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic            out_muldiv,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_writes_rd,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [15:0]     illegal_count
);

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;

    localparam logic [3:0] C_OP_IMM   = 4'd0;
    localparam logic [3:0] C_OP       = 4'd1;
    localparam logic [3:0] C_LOAD     = 4'd2;
    localparam logic [3:0] C_STORE    = 4'd3;
    localparam logic [3:0] C_BRANCH   = 4'd4;
    localparam logic [3:0] C_LUI      = 4'd5;
    localparam logic [3:0] C_AUIPC    = 4'd6;
    localparam logic [3:0] C_JAL      = 4'd7;
    localparam logic [3:0] C_JALR     = 4'd8;
    localparam logic [3:0] C_OP_IMM_W = 4'd9;
    localparam logic [3:0] C_OP_W     = 4'd10;
    localparam logic [3:0] C_ILLEGAL  = 4'd15;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      cls;
        logic [2:0]      funct3;
        logic            alt;
        logic            muldiv;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            writes_rd;
        logic            uses_rs1;
        logic            uses_rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    // ---------------- decode ----------------
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt_imm;
    logic [XLEN-1:0] dec_imm;
    logic [3:0]      dec_cls;
    logic            legal, has_rd, use1, use2, has_tgt, dec_alt, dec_md;
    entry_t          entry_d;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
    assign imm_b = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0});
    assign imm_u = sext32({in_instr[31:12], 12'b0});
    assign imm_j = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0});
    assign shamt_imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

    always_comb begin
        legal   = 1'b1;
        has_rd  = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        has_tgt = 1'b0;
        dec_alt = 1'b0;
        dec_md  = 1'b0;
        dec_imm = '0;
        dec_cls = C_ILLEGAL;
        // Opcodes all end in 2'b11, so the default arm also rejects other low bits.
        case (opc)
            OPC_OP_IMM: begin
                dec_cls = C_OP_IMM;
                has_rd  = 1'b1;
                use1    = 1'b1;
                dec_imm = imm_i;
                if (f3 == 3'b001) begin
                    dec_imm = shamt_imm;
                    legal   = (in_instr[31:26] == 6'b000000) && (XLEN == 64 || !in_instr[25]);
                end else if (f3 == 3'b101) begin
                    dec_imm = shamt_imm;
                    dec_alt = in_instr[30];
                    legal   = (in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000)
                              && (XLEN == 64 || !in_instr[25]);
                end
            end
            OPC_OP: begin
                dec_cls = C_OP;
                has_rd  = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
                dec_alt = in_instr[30];
                case (f7)
                    7'b0000000: legal = 1'b1;
                    7'b0100000: legal = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: begin
                        legal  = HAS_M;
                        dec_md = HAS_M;
                    end
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_W: begin
                dec_cls = C_OP_W;
                has_rd  = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
                dec_alt = in_instr[30];
                case (f7)
                    7'b0000000: legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
                    7'b0100000: legal = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: begin
                        legal  = HAS_M && ((f3 == 3'b000) || f3[2]);
                        dec_md = HAS_M;
                    end
                    default:    legal = 1'b0;
                endcase
                legal = legal && (XLEN == 64);
            end
            OPC_OP_IMM_W: begin
                dec_cls = C_OP_IMM_W;
                has_rd  = 1'b1;
                use1    = 1'b1;
                dec_imm = imm_i;
                case (f3)
                    3'b000: legal = 1'b1;
                    3'b001: begin
                        dec_imm = XLEN'(in_instr[24:20]);
                        legal   = (f7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_imm = XLEN'(in_instr[24:20]);
                        dec_alt = in_instr[30];
                        legal   = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
                legal = legal && (XLEN == 64);
            end
            OPC_LOAD: begin
                dec_cls = C_LOAD;
                has_rd  = 1'b1;
                use1    = 1'b1;
                dec_imm = imm_i;
                legal   = (f3 != 3'b111) &&
                          !(XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                dec_cls = C_STORE;
                use1    = 1'b1;
                use2    = 1'b1;
                dec_imm = imm_s;
                legal   = !f3[2] && !(XLEN == 32 && f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec_cls = C_BRANCH;
                use1    = 1'b1;
                use2    = 1'b1;
                has_tgt = 1'b1;
                dec_imm = imm_b;
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LUI: begin
                dec_cls = C_LUI;
                has_rd  = 1'b1;
                dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                dec_cls = C_AUIPC;
                has_rd  = 1'b1;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                dec_cls = C_JAL;
                has_rd  = 1'b1;
                has_tgt = 1'b1;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                dec_cls = C_JALR;
                has_rd  = 1'b1;
                use1    = 1'b1;
                dec_imm = imm_i;
                legal   = (f3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
    end

    // Register indices a class does not use read as 0, so downstream hazard
    // logic can match on them without also checking the use flags.
    always_comb begin
        entry_d        = '0;
        entry_d.pc     = in_pc;
        entry_d.funct3 = f3;
        if (!legal) begin
            entry_d.cls     = C_ILLEGAL;
            entry_d.illegal = 1'b1;
        end else begin
            entry_d.cls       = dec_cls;
            entry_d.alt       = dec_alt;
            entry_d.muldiv    = dec_md;
            entry_d.rd        = has_rd ? in_instr[11:7] : 5'd0;
            entry_d.rs1       = use1 ? in_instr[19:15] : 5'd0;
            entry_d.rs2       = use2 ? in_instr[24:20] : 5'd0;
            entry_d.writes_rd = has_rd && (in_instr[11:7] != 5'd0);
            entry_d.uses_rs1  = use1;
            entry_d.uses_rs2  = use2;
            entry_d.imm       = dec_imm;
            entry_d.target    = has_tgt ? in_pc + dec_imm : '0;
        end
    end

    // ---------------- output queue ----------------
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on occupancy and flush, never on
    // out_ready, so a full queue stays closed in the cycle it is popped.
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      ill_cnt_q, ill_cnt_d;
    logic             push, pop;
    entry_t           head;

    assign in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = next_ptr(wr_q);
            if (pop)  rd_d = next_ptr(rd_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push && entry_d.illegal && ill_cnt_q != 16'hFFFF)
                ill_cnt_d = ill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= entry_d;
    end

    assign head = out_valid ? mem_q[rd_q] : '0;

    assign out_pc        = head.pc;
    assign out_class     = head.cls;
    assign out_funct3    = head.funct3;
    assign out_alt       = head.alt;
    assign out_muldiv    = head.muldiv;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_writes_rd = head.writes_rd;
    assign out_uses_rs1  = head.uses_rs1;
    assign out_uses_rs2  = head.uses_rs2;
    assign out_imm       = head.imm;
    assign out_target    = head.target;
    assign out_illegal   = head.illegal;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: an RV64+M instance and an RV32 no-M instance share
// one stimulus stream; a negedge monitor pops per-instance expected queues.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic        md;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic        u1;
        logic        u2;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        exp_t        e64;
        exp_t        e32;
    } vec_t;

    // ---------------- clock / reset / shared inputs ----------------
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    always #5 clk = ~clk;

    // RV64, M extension
    logic        a_in_ready, a_out_valid, a_alt, a_md, a_wr, a_u1, a_u2, a_ill;
    logic [63:0] a_pc, a_imm, a_tgt;
    logic [3:0]  a_cls;
    logic [2:0]  a_f3;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [15:0] a_cnt;

    // RV32, no M extension
    logic        b_in_ready, b_out_valid, b_alt, b_md, b_wr, b_u1, b_u2, b_ill;
    logic [31:0] b_pc, b_imm, b_tgt;
    logic [3:0]  b_cls;
    logic [2:0]  b_f3;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [15:0] b_cnt;

    rv_decode_stage #(.XLEN(64), .HAS_M(1'b1), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_class(a_cls),
        .out_funct3(a_f3), .out_alt(a_alt), .out_muldiv(a_md),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_writes_rd(a_wr), .out_uses_rs1(a_u1), .out_uses_rs2(a_u2),
        .out_imm(a_imm), .out_target(a_tgt), .out_illegal(a_ill), .illegal_count(a_cnt)
    );

    rv_decode_stage #(.XLEN(32), .HAS_M(1'b0), .DEPTH(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_class(b_cls),
        .out_funct3(b_f3), .out_alt(b_alt), .out_muldiv(b_md),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_writes_rd(b_wr), .out_uses_rs1(b_u1), .out_uses_rs2(b_u2),
        .out_imm(b_imm), .out_target(b_tgt), .out_illegal(b_ill), .illegal_count(b_cnt)
    );

    // ---------------- scoreboard state ----------------
    exp_t q64[$];
    exp_t q32[$];
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[14];

    function automatic exp_t mk(input logic [63:0] pc, input logic [3:0] cls,
                                input logic [2:0] f3, input logic alt, input logic md,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic wr, input logic u1,
                                input logic u2, input logic [63:0] imm,
                                input logic [63:0] tgt);
        exp_t e;
        e.pc = pc;   e.cls = cls; e.f3 = f3;   e.alt = alt; e.md = md;
        e.rd = rd;   e.rs1 = rs1; e.rs2 = rs2; e.wr = wr;   e.u1 = u1;
        e.u2 = u2;   e.imm = imm; e.tgt = tgt; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t ill(input logic [63:0] pc, input logic [2:0] f3);
        exp_t e;
        e     = '0;
        e.pc  = pc;
        e.cls = 4'd15;
        e.f3  = f3;
        e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t x32(input exp_t e);
        exp_t r;
        r = e;
        r.pc[63:32]  = '0;
        r.imm[63:32] = '0;
        r.tgt[63:32] = '0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_entry(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s pc=%h: got cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h tgt=%h bundle=%h expected cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h tgt=%h bundle=%h",
                     name, exp.pc, act.cls, act.rd, act.rs1, act.rs2, act.imm, act.tgt, act,
                     exp.cls, exp.rd, exp.rs1, exp.rs2, exp.imm, exp.tgt, exp);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t m_act, m_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && out_ready) begin
                m_act = '{pc: a_pc, cls: a_cls, f3: a_f3, alt: a_alt, md: a_md,
                          rd: a_rd, rs1: a_rs1, rs2: a_rs2, wr: a_wr, u1: a_u1,
                          u2: a_u2, imm: a_imm, tgt: a_tgt, ill: a_ill};
                if (q64.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d64_unexpected: got entry pc=%h expected no output", a_pc);
                end else begin
                    m_exp = q64.pop_front();
                    cmp_entry("d64_entry", m_act, m_exp);
                end
            end
            if (b_out_valid && out_ready) begin
                m_act = '{pc: {32'b0, b_pc}, cls: b_cls, f3: b_f3, alt: b_alt, md: b_md,
                          rd: b_rd, rs1: b_rs1, rs2: b_rs2, wr: b_wr, u1: b_u1,
                          u2: b_u2, imm: {32'b0, b_imm}, tgt: {32'b0, b_tgt}, ill: b_ill};
                if (q32.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d32_unexpected: got entry pc=%h expected no output", b_pc);
                end else begin
                    m_exp = q32.pop_front();
                    cmp_entry("d32_entry", m_act, m_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] instr, input logic [63:0] pc,
                        input exp_t e64, input exp_t e32);
        bit acc;
        int n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = a_in_ready;
            if (acc) begin
                q64.push_back(e64);
                q32.push_back(e32);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 64'(q64.size() + q32.size()), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected $finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        exp_t e64, e32;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;

        // instr, pc, RV64+M expectation, RV32 no-M expectation
        vecs[0]  = '{32'hFFF50513, 64'h100,
                     mk(64'h100, 0, 0, 0, 0, 10, 10, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0), '0};
        vecs[1]  = '{32'h00113423, 64'h104,
                     mk(64'h104, 3, 3, 0, 0, 0, 2, 1, 0, 1, 1, 64'd8, 0), ill(64'h104, 3)};
        vecs[2]  = '{32'hFEB50EE3, 64'h1000,
                     mk(64'h1000, 4, 0, 0, 0, 0, 10, 11, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC), '0};
        vecs[3]  = '{32'hFEB50EE3, 64'h0,
                     mk(64'h0, 4, 0, 0, 0, 0, 10, 11, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                        64'hFFFF_FFFF_FFFF_FFFC), '0};
        vecs[4]  = '{32'h02B50533, 64'h108,
                     mk(64'h108, 1, 0, 0, 1, 10, 10, 11, 1, 1, 1, 0, 0), ill(64'h108, 0)};
        vecs[5]  = '{32'h00B5053B, 64'h10C,
                     mk(64'h10C, 10, 0, 0, 0, 10, 10, 11, 1, 1, 1, 0, 0), ill(64'h10C, 0)};
        vecs[6]  = '{32'h40E68633, 64'h110,
                     mk(64'h110, 1, 0, 1, 0, 12, 13, 14, 1, 1, 1, 0, 0), '0};
        vecs[7]  = '{32'h42155513, 64'h114,
                     mk(64'h114, 0, 5, 1, 0, 10, 10, 0, 1, 1, 0, 64'd33, 0), ill(64'h114, 5)};
        vecs[8]  = '{32'h80000537, 64'h118,
                     mk(64'h118, 5, 0, 0, 0, 10, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_8000_0000, 0), '0};
        vecs[9]  = '{32'h008000EF, 64'h2000,
                     mk(64'h2000, 7, 0, 0, 0, 1, 0, 0, 1, 0, 0, 64'd8, 64'h2008), '0};
        vecs[10] = '{32'h000110E7, 64'h11C, ill(64'h11C, 1), '0};
        vecs[11] = '{32'h00000000, 64'h120, ill(64'h120, 0), '0};
        vecs[12] = '{32'h01013503, 64'h124,
                     mk(64'h124, 2, 3, 0, 0, 10, 2, 0, 1, 1, 0, 64'd16, 0), ill(64'h124, 3)};
        vecs[13] = '{32'h00000013, 64'h128,
                     mk(64'h128, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), '0};
        // entries that decode identically on both instances
        foreach (vecs[i]) begin
            if (vecs[i].e32 == '0) vecs[i].e32 = x32(vecs[i].e64);
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid64", 64'(a_out_valid), 64'd0);
        check("rst_out_valid32", 64'(b_out_valid), 64'd0);
        check("rst_count64", 64'(a_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready64", 64'(a_in_ready), 64'd1);
        check("rst_in_ready32", 64'(b_in_ready), 64'd1);
        check("rst_out_pc64", a_pc, 64'd0);
        check("rst_out_imm64", a_imm, 64'd0);
        check("rst_out_class64", 64'(a_cls), 64'd0);
        @(posedge clk);
        #1;

        // first-entry latency: visible the cycle after acceptance
        push(vecs[0].instr, vecs[0].pc, vecs[0].e64, vecs[0].e32);
        @(negedge clk);
        check("latency_valid64", 64'(a_out_valid), 64'd1);
        check("latency_valid32", 64'(b_out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 1; i < 14; i++) push(vecs[i].instr, vecs[i].pc, vecs[i].e64, vecs[i].e32);
        wait_drain();
        check("ill_count64", 64'(a_cnt), 64'd2);
        check("ill_count32", 64'(b_cnt), 64'd7);

        // backpressure: two accepted, third held until the cycle after the first pop
        out_ready = 1'b0;
        e64 = vecs[0].e64; e64.pc = 64'h3000; e32 = x32(e64);
        push(vecs[0].instr, 64'h3000, e64, e32);
        e64 = vecs[6].e64; e64.pc = 64'h3004; e32 = x32(e64);
        push(vecs[6].instr, 64'h3004, e64, e32);
        in_valid = 1'b1;
        in_instr = vecs[8].instr;
        in_pc    = 64'h3008;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_in_ready64", 64'(a_in_ready), 64'd0);
            check("full_in_ready32", 64'(b_in_ready), 64'd0);
            check("stall_head_pc64", a_pc, 64'h3000);
            check("stall_head_imm64", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_in_ready64", 64'(a_in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_pop_in_ready64", 64'(a_in_ready), 64'd1);
        check("after_pop_in_ready32", 64'(b_in_ready), 64'd1);
        e64 = vecs[8].e64; e64.pc = 64'h3008;
        q64.push_back(e64);
        q32.push_back(x32(e64));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // flush with two queued entries and an illegal word presented alongside
        out_ready = 1'b0;
        e64 = vecs[0].e64; e64.pc = 64'h4000; e32 = x32(e64);
        push(vecs[0].instr, 64'h4000, e64, e32);
        e64 = vecs[6].e64; e64.pc = 64'h4004; e32 = x32(e64);
        push(vecs[6].instr, 64'h4004, e64, e32);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        in_pc    = 64'h4008;
        @(negedge clk);
        check("flush_in_ready64", 64'(a_in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q64.delete();
        q32.delete();
        @(negedge clk);
        check("flush_out_valid64", 64'(a_out_valid), 64'd0);
        check("flush_out_valid32", 64'(b_out_valid), 64'd0);
        check("flush_out_pc64", a_pc, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_ill_count64", 64'(a_cnt), 64'd2);
        check("flush_ill_count32", 64'(b_cnt), 64'd7);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        push(32'h00000000, 64'h5000, ill(64'h5000, 0), x32(ill(64'h5000, 0)));
        e64 = vecs[0].e64; e64.pc = 64'h5004; e32 = x32(e64);
        push(vecs[0].instr, 64'h5004, e64, e32);
        @(negedge clk);
        check("pre_rst_count64", 64'(a_cnt), 64'd3);
        check("pre_rst_count32", 64'(b_cnt), 64'd8);
        check("pre_rst_head_ill64", 64'(a_ill), 64'd1);
        #2;
        rst_n = 1'b0;
        q64.delete();
        q32.delete();
        #1;
        check("async_rst_valid64", 64'(a_out_valid), 64'd0);
        check("async_rst_valid32", 64'(b_out_valid), 64'd0);
        check("async_rst_count64", 64'(a_cnt), 64'd0);
        check("async_rst_count32", 64'(b_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready64", 64'(a_in_ready), 64'd1);
        check("post_rst_valid64", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Pipelined, parametrised RISC-V instruction decode stage. It sits between instruction fetch and the execute/issue stage. It converts each 32-bit instruction into a registered control bundle: register indices, sign-extended immediate, class, ALU op and branch/jump target. It is generalised over XLEN (RV32/RV64) and M-extension support, adds illegal-instruction detection, uses a valid/ready handshake with an output queue, supports flush, and keeps a saturating illegal-instruction counter.

Parameters:
XLEN, 64, datapath width; legal values are 32 and 64.
HAS_M, 1, decode the M extension (funct7=0000001 on OP and OP-32); 0 makes these encodings illegal.
DEPTH, 2, output queue entries; minimum 1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all queued entries and any same-cycle input
in_valid  in  1  instruction presented
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_pc  out  XLEN  pc of head
out_class  out  4  0 OP_IMM, 1 OP, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 OP_IMM_W, 10 OP_W, 15 ILLEGAL
out_funct3  out  3  instr[14:12]
out_alt  out  1  instr[30] for OP/OP_W/shift-right-imm; 0 otherwise
out_muldiv  out  1  M-extension op
out_rd, out_rs1, out_rs2  out  5 each  register indices
out_writes_rd, out_uses_rs1, out_uses_rs2  out  1 each  register-use flags
out_imm  out  XLEN  sign-extended immediate
out_target  out  XLEN  pc+imm for BRANCH/JAL; 0 otherwise
out_illegal  out  1  head entry is illegal
illegal_count  out  16  saturating count of illegal instructions accepted

Behaviour:
Reset (async, rst_n=0):
- Queue empty; out_valid=0; illegal_count=0.
- All out_* data fields read 0 while out_valid=0 (driven 0 when the queue is empty).
- in_ready=1 once rst_n is deasserted.
- A reset mid-operation discards all entries immediately.

Handshake:
- Push on in_valid&in_ready; pop on out_valid&out_ready.
- in_ready = (count<DEPTH) & ~flush. There is no combinational pass-through when full, so a same-cycle pop does not open in_ready.
- Latency: an instruction accepted in cycle N appears at the output in cycle N+1 if the queue was empty.
- Simultaneous push and pop leave count unchanged. Order is strictly FIFO.
- Head fields are stable while out_valid=1 and out_ready=0.

Flush:
- Synchronous; takes priority over push and pop.
- Next cycle count=0 and out_valid=0.
- An instruction presented in the flush cycle is dropped and is not counted.

Decode (combinational on in_instr, captured at push):
- Immediate formats, each sign-extended from instr[31] to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Shift-immediate ops: imm = zero-extended shamt. The shamt is 6 bits for XLEN=64 and for OP_IMM; 5 bits for OP_IMM_W and for XLEN=32.
- out_target = in_pc + imm, computed modulo 2^XLEN.
- Flags:
  - uses_rs1 = 0 for LUI, AUIPC and JAL; 1 for all other legal classes.
  - uses_rs2 = 1 for OP, OP_W, STORE and BRANCH.
  - writes_rd = 0 for STORE and BRANCH, or when rd=0.

Illegal conditions:
- Unknown opcode.
- Low two bits not 11.
- Reserved funct3: BRANCH 010/011; LOAD 111, plus 011/110 when XLEN=32; STORE 1xx, plus 011 when XLEN=32.
- funct7 not in {0000000, 0100000 (only where valid), 0000001 (only if HAS_M)}.
- OP_IMM_W/OP_W when XLEN=32.
- shamt[5]=1 when XLEN=32.
- JALR funct3≠000.

Illegal entries:
- out_class=15 and out_illegal=1.
- rd/rs1/rs2, flags, imm and target are all 0.
- out_pc is preserved.
- illegal_count increments on the push of an illegal entry and saturates at 0xFFFF.

Test Plan:
- XLEN=64: push 0xFFF50513 (addi a0,a0,-1) -> next cycle out_valid=1, class=0, rd=10, rs1=10, uses_rs2=0, imm=0xFFFFFFFFFFFFFFFF.
- Push 0x00113423 (sd ra,8(sp)) -> class=3, rs1=2, rs2=1, imm=8, writes_rd=0, funct3=3. With XLEN=32 the same word gives illegal=1 and illegal_count=1.
- Push 0xFEB50EE3 (beq a0,a1,-4) at pc=0x1000 -> class=4, imm=-4, target=0xFFC. Push the same word at pc=0 -> target=0xFFFFFFFFFFFFFFFC (wrap).
- DEPTH=2, out_ready=0: push 3 back-to-back -> in_ready=0 after 2 accepts, 3rd held. Raise out_ready -> entries emerge in order, 3rd accepted one cycle after the first pop.
- HAS_M=0: push 0x02B50533 (mul a0,a0,a1) -> class=15, illegal=1. XLEN=32: push 0x00B5053B (addw) -> illegal, illegal_count=2.
- Queue holding 2 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, dropped instruction never appears. Assert rst_n=0 mid-stream -> out_valid=0 and illegal_count=0 immediately.
